mvm_tile_ctrl: RTL and testbench

- Sequencer that time-multiplexes one combinational matrix-vector multiplier (MVM) datapath over a weight matrix wider than the datapath.
- On start, latches the input vector, then walks NUM_TILES column tiles:
  - fetches each tile of weights from a synchronous weight memory;
  - drives the tile and vector into the MVM;
  - registers the MVM result and hands it downstream over a valid/ready stream.
- Sits between the layer scheduler (start/done), the weight RAM and the MVM datapath.

---
 rtl/mvm_pkg.sv | 7 +
 rtl/mvm_result_reg.sv | 29 ++
 rtl/mvm_tile_ctrl.sv | 103 ++++++++++
 tb/tb_mvm_tile_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// mvm_pkg: shared FSM state encoding and result-width helper for the MVM tile sequencer
package mvm_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, COMPUTE, EMIT, DONE} state_e;
  function automatic int out_w(input int width, input int vector_size);
    return 2 * width + vector_size;
  endfunction
endpackage

// File: rtl/mvm_result_reg.sv
// mvm_result_reg: result register loaded in COMPUTE and held with valid until downstream accepts
module mvm_result_reg #(
  parameter int DW = 39,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          ready_i,
  input  logic [DW-1:0] data_i,
  input  logic [TW-1:0] tile_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [TW-1:0] tile_o
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      tile_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      tile_o  <= tile_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: rtl/mvm_tile_ctrl.sv
// mvm_tile_ctrl: walks weight tiles through an external MVM; MVM_TILE_CTRL_PERF_EN adds a stall counter
module mvm_tile_ctrl
  import mvm_pkg::*;
#(
  parameter int VECTOR_SIZE     = 3,
  parameter int MATRIX_COLUMNS  = 3,
  parameter int WIDTH_ELEMENT   = 5,
  parameter int NUM_TILES       = 4,
  parameter int TILE_ADDR_WIDTH = 2,
  localparam int OUT_W = out_w(WIDTH_ELEMENT, VECTOR_SIZE),
  localparam int VW    = VECTOR_SIZE * WIDTH_ELEMENT,
  localparam int MW    = VECTOR_SIZE * MATRIX_COLUMNS * WIDTH_ELEMENT,
  localparam int RW    = OUT_W * MATRIX_COLUMNS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [VW-1:0]              vector_in,
  output logic                       busy,
  output logic                       done,
  output logic                       w_rd_en,
  output logic [TILE_ADDR_WIDTH-1:0] w_addr,
  input  logic [MW-1:0]              w_data,
  output logic [VW-1:0]              mvm_vector,
  output logic [MW-1:0]              mvm_matrix,
  input  logic [RW-1:0]              mvm_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [RW-1:0]              res_data,
  output logic [TILE_ADDR_WIDTH-1:0] res_tile
`ifdef MVM_TILE_CTRL_PERF_EN
  ,output logic [15:0]               stall_cycles
`endif
);
  state_e state_q, state_d;
  logic [TILE_ADDR_WIDTH-1:0] tile_q;
  logic busy_q, done_q, rd_q;
  logic [VW-1:0] vec_q;
  logic [MW-1:0] mat_q;
  logic accept, hs, last;
  assign accept = (state_q == IDLE) && start;
  assign hs     = res_valid && res_ready;
  assign last   = tile_q == TILE_ADDR_WIDTH'(NUM_TILES - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = COMPUTE;
      COMPUTE: state_d = EMIT;
      EMIT:    state_d = hs ? (last ? DONE : FETCH) : EMIT;
      default: state_d = IDLE;
    endcase
  end
  // Status outputs are decoded from the next state so they are flops aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tile_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      vec_q   <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      rd_q    <= state_d == FETCH;
      if (accept) begin
        vec_q  <= vector_in;
        tile_q <= '0;
      end
      if (state_q == EMIT && hs && !last) tile_q <= tile_q + 1'b1;
      if (state_q == WAIT) mat_q <= w_data;
    end
  end
  mvm_result_reg #(.DW(RW), .TW(TILE_ADDR_WIDTH)) u_res (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == COMPUTE),
    .ready_i(res_ready),
    .data_i (mvm_out),
    .tile_i (tile_q),
    .valid_o(res_valid),
    .data_o (res_data),
    .tile_o (res_tile)
  );
  assign busy       = busy_q;
  assign done       = done_q;
  assign w_rd_en    = rd_q;
  assign w_addr     = tile_q;
  assign mvm_vector = vec_q;
  assign mvm_matrix = mat_q;
`ifdef MVM_TILE_CTRL_PERF_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || accept) stall_q <= '0;
    else if (res_valid && !res_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mvm_tile_ctrl.sv
// tb_mvm_tile_ctrl: randomized self-checking bench with weight RAM, MVM and result reference model
module tb_mvm_tile_ctrl;
  localparam int VS = 3, MC = 3, WE = 5, NT = 4, TAW = 2;
  localparam int OW = 2 * WE + VS, VW = VS * WE, MW = VS * MC * WE, RW = OW * MC;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0, res_ready = 1'b1;
  logic [VW-1:0] vector_in = '0;
  logic busy, done, w_rd_en, res_valid;
  logic [TAW-1:0] w_addr, res_tile;
  logic [MW-1:0] w_data, mvm_matrix;
  logic [VW-1:0] mvm_vector;
  logic [RW-1:0] mvm_out, res_data;

  logic s_start = 1'b0, s_res_ready = 1'b1;
  logic [VW-1:0] s_vector_in = '0;
  logic s_busy, s_done, s_w_rd_en, s_res_valid;
  logic [TAW-1:0] s_w_addr, s_res_tile;
  logic [MW-1:0] s_w_data, s_mvm_matrix;
  logic [VW-1:0] s_mvm_vector;
  logic [RW-1:0] s_mvm_out, s_res_data;
`ifdef MVM_TILE_CTRL_PERF_EN
  logic [15:0] stall_cycles, s_stall_cycles;
`endif

  mvm_tile_ctrl #(.VECTOR_SIZE(VS), .MATRIX_COLUMNS(MC), .WIDTH_ELEMENT(WE),
                  .NUM_TILES(NT), .TILE_ADDR_WIDTH(TAW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vector_in(vector_in), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .mvm_vector(mvm_vector),
    .mvm_matrix(mvm_matrix), .mvm_out(mvm_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tile(res_tile)
`ifdef MVM_TILE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  mvm_tile_ctrl #(.VECTOR_SIZE(VS), .MATRIX_COLUMNS(MC), .WIDTH_ELEMENT(WE),
                  .NUM_TILES(1), .TILE_ADDR_WIDTH(TAW)) u_one (
    .clk(clk), .rst(rst), .start(s_start), .vector_in(s_vector_in), .busy(s_busy), .done(s_done),
    .w_rd_en(s_w_rd_en), .w_addr(s_w_addr), .w_data(s_w_data), .mvm_vector(s_mvm_vector),
    .mvm_matrix(s_mvm_matrix), .mvm_out(s_mvm_out), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_data(s_res_data), .res_tile(s_res_tile)
`ifdef MVM_TILE_CTRL_PERF_EN
    , .stall_cycles(s_stall_cycles)
`endif
  );

  // Weight RAM (1-cycle read latency) and combinational MVM, element (row i, column c) at (c*VS+i)*WE
  logic [MW-1:0] ram [NT];
  int wt [NT][VS][MC];
  int vec_m [VS];
  always @(posedge clk) if (w_rd_en) w_data <= ram[w_addr];
  always @(posedge clk) if (s_w_rd_en) s_w_data <= ram[s_w_addr];

  function automatic logic [RW-1:0] mvm_f(input logic [VW-1:0] v, input logic [MW-1:0] m);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < MC; c++)
      for (int i = 0; i < VS; i++)
        r[c*OW +: OW] += OW'(v[i*WE +: WE]) * OW'(m[(c*VS+i)*WE +: WE]);
    return r;
  endfunction
  assign mvm_out   = mvm_f(mvm_vector, mvm_matrix);
  assign s_mvm_out = mvm_f(s_mvm_vector, s_mvm_matrix);

  function automatic int exp_col(input int k, input int c);
    int s;
    s = 0;
    for (int i = 0; i < VS; i++) s += vec_m[i] * wt[k][i][c];
    return s;
  endfunction

  task automatic set_weights(input bit fixed);
    logic [MW-1:0] w;
    for (int k = 0; k < NT; k++) begin
      w = '0;
      for (int i = 0; i < VS; i++)
        for (int c = 0; c < MC; c++) begin
          wt[k][i][c] = fixed ? k + 1 : int'($urandom_range(0, 31));
          w[(c*VS+i)*WE +: WE] = WE'(wt[k][i][c]);
        end
      ram[k] = w;
    end
  endtask

  int checks = 0, errors = 0;
  int hs_cyc [NT], hs_tile [NT];
  logic [RW-1:0] hs_data [NT];
  int n_hs, n_done, done_cyc, n_rd, stall_rd, stall_viol, st_seen;

  // Runs one job from IDLE and records what the DUT did; comparisons live in the test tasks.
  task automatic do_run(input logic [VW-1:0] vec, input int st_tile, input int st_len, input bit poke);
    logic [RW-1:0] held_d;
    logic [TAW-1:0] held_t;
    n_hs = 0; n_done = 0; done_cyc = -1; n_rd = 0; stall_rd = 0; stall_viol = 0; st_seen = 0;
    held_d = '0; held_t = '0;
    for (int i = 0; i < VS; i++) vec_m[i] = int'(vec[i*WE +: WE]);
    vector_in = vec; start = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < 200 && !(done_cyc >= 0 && n > done_cyc + 2); n++) begin
      if (poke) begin
        start = busy;
        vector_in = VW'($urandom);
      end
      res_ready = !(res_valid && int'(res_tile) == st_tile && st_seen < st_len);
      if (res_valid && !res_ready) begin
        if (st_seen == 0) begin held_d = res_data; held_t = res_tile; end
        else if (res_data !== held_d || res_tile !== held_t) stall_viol++;
        if (w_rd_en) stall_rd++;
        st_seen++;
      end
      if (w_rd_en) n_rd++;
      if (res_valid && res_ready && n_hs < NT) begin
        hs_cyc[n_hs] = n; hs_tile[n_hs] = int'(res_tile); hs_data[n_hs] = res_data; n_hs++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = n;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; res_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || w_rd_en !== 1'b0) begin errors++;
      $display("FAIL reset_status busy=%b done=%b rd=%b exp 0", busy, done, w_rd_en); end
    checks++; if (res_valid !== 1'b0 || res_data !== '0 || res_tile !== '0 || w_addr !== '0) begin errors++;
      $display("FAIL reset_result valid=%b data=%h tile=%0d addr=%0d exp 0", res_valid, res_data, res_tile, w_addr); end
    checks++; if (mvm_vector !== '0 || mvm_matrix !== '0) begin errors++;
      $display("FAIL reset_mvm vec=%h mat=%h exp 0", mvm_vector, mvm_matrix); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_run;
    set_weights(1'b1);
    do_run({5'd3, 5'd2, 5'd1}, -1, 0, 1'b0);
    checks++; if (n_hs !== NT) begin errors++; $display("FAIL run_count got %0d exp %0d", n_hs, NT); end
    for (int k = 0; k < n_hs; k++) begin
      checks++; if (hs_tile[k] !== k || hs_cyc[k] !== 4 + 4 * k) begin errors++;
        $display("FAIL run_tile%0d got tile %0d cyc %0d exp tile %0d cyc %0d", k, hs_tile[k], hs_cyc[k], k, 4 + 4 * k); end
      for (int c = 0; c < MC; c++) begin
        checks++; if (hs_data[k][c*OW +: OW] !== OW'(6 * (k + 1))) begin errors++;
          $display("FAIL run_data t%0d c%0d got %0d exp %0d", k, c, hs_data[k][c*OW +: OW], 6 * (k + 1)); end
      end
    end
    checks++; if (done_cyc !== 17 || n_done !== 1) begin errors++;
      $display("FAIL run_done got cyc %0d count %0d exp cyc 17 count 1", done_cyc, n_done); end
    checks++; if (n_rd !== NT) begin errors++; $display("FAIL run_reads got %0d exp %0d", n_rd, NT); end
  endtask

  task automatic check_results(input string tag, input int st_len);
    checks++; if (n_hs !== NT) begin errors++; $display("FAIL %s_count got %0d exp %0d", tag, n_hs, NT); end
    for (int k = 0; k < n_hs; k++) begin
      checks++; if (hs_tile[k] !== k || hs_cyc[k] !== 4 + 4 * k + (k >= 1 ? st_len : 0)) begin errors++;
        $display("FAIL %s_tile%0d got tile %0d cyc %0d exp cyc %0d", tag, k, hs_tile[k], hs_cyc[k], 4 + 4 * k + (k >= 1 ? st_len : 0)); end
      for (int c = 0; c < MC; c++) begin
        checks++; if (hs_data[k][c*OW +: OW] !== OW'(exp_col(k, c))) begin errors++;
          $display("FAIL %s_data t%0d c%0d got %0d exp %0d", tag, k, c, hs_data[k][c*OW +: OW], exp_col(k, c)); end
      end
    end
    checks++; if (done_cyc !== 17 + st_len || n_done !== 1) begin errors++;
      $display("FAIL %s_done got cyc %0d count %0d exp cyc %0d count 1", tag, done_cyc, n_done, 17 + st_len); end
  endtask

  task automatic test_backpressure;
    set_weights(1'b0);
    do_run(VW'($urandom), 1, 5, 1'b0);
    check_results("bp", 5);
    checks++; if (st_seen !== 5 || stall_viol !== 0 || stall_rd !== 0) begin errors++;
      $display("FAIL bp_hold got stall %0d changes %0d reads %0d exp 5 0 0", st_seen, stall_viol, stall_rd); end
  endtask

  task automatic test_start_ignored;
    set_weights(1'b0);
    do_run(VW'($urandom), -1, 0, 1'b1);
    check_results("ign", 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_restart busy=%b exp 0", busy); end
  endtask

  task automatic test_rst_mid_run;
    int extra_done;
    set_weights(1'b0);
    vector_in = VW'($urandom); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (w_addr !== 2'd2 || busy !== 1'b1) begin errors++;
      $display("FAIL rst_pos got addr %0d busy %b exp 2 1", w_addr, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || w_rd_en !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL rst_abort busy=%b valid=%b rd=%b done=%b exp 0", busy, res_valid, w_rd_en, done); end
    rst = 1'b0;
    extra_done = 0;
    repeat (6) begin @(posedge clk); #1; if (done || busy) extra_done++; end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL rst_quiet got %0d active cycles exp 0", extra_done); end
    do_run(VW'($urandom), -1, 0, 1'b0);
    check_results("rst", 0);
  endtask

  task automatic test_single_tile;
    int v_cyc, d_cyc, nd;
    logic [RW-1:0] d;
    logic [TAW-1:0] t;
    logic [VW-1:0] v;
    set_weights(1'b0);
    v = VW'($urandom);
    for (int i = 0; i < VS; i++) vec_m[i] = int'(v[i*WE +: WE]);
    v_cyc = -1; d_cyc = -1; nd = 0; d = '0; t = '1;
    s_vector_in = v; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int n = 1; n < 10; n++) begin
      if (s_res_valid && v_cyc < 0) begin v_cyc = n; d = s_res_data; t = s_res_tile; end
      if (s_done) begin nd++; if (d_cyc < 0) d_cyc = n; end
      @(posedge clk); #1;
    end
    checks++; if (v_cyc !== 4 || t !== 2'd0) begin errors++;
      $display("FAIL one_result got cyc %0d tile %0d exp 4 0", v_cyc, t); end
    for (int c = 0; c < MC; c++) begin
      checks++; if (d[c*OW +: OW] !== OW'(exp_col(0, c))) begin errors++;
        $display("FAIL one_data c%0d got %0d exp %0d", c, d[c*OW +: OW], exp_col(0, c)); end
    end
    checks++; if (d_cyc !== 5 || nd !== 1) begin errors++;
      $display("FAIL one_done got cyc %0d count %0d exp 5 1", d_cyc, nd); end
  endtask

`ifdef MVM_TILE_CTRL_PERF_EN
  task automatic test_perf;
    set_weights(1'b0);
    do_run(VW'($urandom), 1, 5, 1'b0);
    checks++; if (stall_cycles !== 16'd5) begin errors++; $display("FAIL perf_count got %0d exp 5", stall_cycles); end
    vector_in = VW'($urandom); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL perf_clear got %0d exp 0", stall_cycles); end
    repeat (20) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset;
    test_single_run;
    test_backpressure;
    test_start_ignored;
    test_rst_mid_run;
    test_single_tile;
`ifdef MVM_TILE_CTRL_PERF_EN
    test_perf;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
